// File: rtl/ad7324_pkg.sv
// ad7324_pkg
//   Shared constants for the AD7324 serial link: frame length, channel data
//   width, control-register field positions, sequencer mode encodings and
//   the TX/RX frame field positions used by both master and responder.
package ad7324_pkg;

    // Frame geometry
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CH_BITS    = 13;
    localparam int unsigned CTRL_BITS  = 12;

    // Register select carried in the RX frame
    localparam logic [1:0] REG_CTRL = 2'b00;

    // RX (DIN) frame fields
    localparam int unsigned RX_WRITE_BIT = 15;
    localparam int unsigned RX_REG_MSB   = 14;
    localparam int unsigned RX_REG_LSB   = 13;

    // TX (DOUT) frame fields: {zero, channel id, 13-bit result}
    localparam int unsigned TX_ID_MSB = 14;
    localparam int unsigned TX_ID_LSB = 13;

    // Control register fields
    localparam int unsigned CTRL_ADD_MSB = 11;
    localparam int unsigned CTRL_ADD_LSB = 10;
    localparam int unsigned CTRL_SEQ_MSB = 4;
    localparam int unsigned CTRL_SEQ_LSB = 3;

    typedef enum logic [1:0] {
        SEQ_OFF     = 2'b00,
        SEQ_SHADOW  = 2'b01,
        SEQ_OFF_ALT = 2'b10,
        SEQ_CONSEC  = 2'b11
    } seq_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } resp_state_e;

    function automatic logic [FRAME_BITS-1:0] make_tx_word(
        input logic [1:0]         ch,
        input logic [CH_BITS-1:0] data
    );
        return {1'b0, ch, data};
    endfunction

endpackage

// File: rtl/ad7324_spi_responder_edge_sync.sv
// spi_edge_sync
//   Multi-flop synchroniser for one asynchronous input followed by a single
//   history flop that yields one-cycle rise/fall strobes aligned with the
//   synchronised level.
// Ports
//   clk_i    system clock
//   rst_i    synchronous active-high reset (chain loads RST_VAL)
//   async_i  asynchronous input
//   level_o  synchronised level
//   rise_o   1-cycle strobe on synchronised 0->1
//   fall_o   1-cycle strobe on synchronised 1->0
module spi_edge_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ad7324_spi_responder.sv
// ad7324_spi_responder
//   Device end of an AD7324-style SPI link. Decodes control-register writes
//   from d_in and returns 16-bit result frames {0, ch_id[1:0], data[12:0]}
//   on d_out, taking channel data from the parallel ch_data bus.
// Ports
//   clk         system clock (SPI clock must be <= clk/4)
//   rst         synchronous active-high reset
//   cs          chip select, active low, asynchronous
//   clk_in      SPI clock from master, idles high, asynchronous
//   d_in        serial data from master, sampled on clk_in falling edges
//   d_out       serial data to master, updated on clk_in falling edges
//   ch_data     4 x 13-bit channel results, ch n = [13n+12:13n]
//   ctrl_reg    current control register
//   frame_done  1-cycle pulse after a complete 16-bit frame
//   frame_err   1-cycle pulse after a frame aborted before bit 16
module ad7324_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        clk_in,
    input  logic        d_in,
    output logic        d_out,
    input  logic [51:0] ch_data,
    output logic [11:0] ctrl_reg,
    output logic        frame_done,
    output logic        frame_err
);

    import ad7324_pkg::*;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic din_s, din_rise, din_fall;

    // cs chain resets low so a frame can only start after cs has been seen
    // high: a reset asserted mid-frame never produces a spurious start.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (cs),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (clk_in),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (d_in),
        .level_o (din_s),
        .rise_o  (din_rise),
        .fall_o  (din_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    resp_state_e           state_q,   state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_sr_q,   tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q,   rx_sr_d;
    logic                  d_out_q,   d_out_d;
    logic [CTRL_BITS-1:0]  ctrl_q,    ctrl_d;
    logic [1:0]            seq_ptr_q, seq_ptr_d;
    logic [1:0]            conv_ch_q, conv_ch_d;
    logic                  done_q,    done_d;
    logic                  err_q,     err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            d_out_q   <= 1'b0;
            ctrl_q    <= '0;
            seq_ptr_q <= '0;
            conv_ch_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            d_out_q   <= d_out_d;
            ctrl_q    <= ctrl_d;
            seq_ptr_q <= seq_ptr_d;
            conv_ch_q <= conv_ch_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Channel select for the frame about to start
    // ------------------------------------------------------------------
    logic [CH_BITS-1:0]    ch_arr [NUM_CH];
    logic [FRAME_BITS-1:0] tx_new;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_arr[i] = ch_data[i*CH_BITS +: CH_BITS];
        end
        tx_new = make_tx_word(conv_ch_q, ch_arr[conv_ch_q]);
    end

    // ------------------------------------------------------------------
    // End-of-frame decode: control write, then next conversion channel
    // ------------------------------------------------------------------
    logic                 wr_ctrl;
    logic [CTRL_BITS-1:0] ctrl_new;
    seq_mode_e            seq_new;
    logic [1:0]           add_new;
    logic [1:0]           ptr_base;
    logic [1:0]           conv_next;
    logic [1:0]           ptr_next;

    always_comb begin
        wr_ctrl  = rx_sr_q[RX_WRITE_BIT] &&
                   (rx_sr_q[RX_REG_MSB:RX_REG_LSB] == REG_CTRL);
        ctrl_new = wr_ctrl ? rx_sr_q[CTRL_BITS-1:0] : ctrl_q;
        seq_new  = seq_mode_e'(ctrl_new[CTRL_SEQ_MSB:CTRL_SEQ_LSB]);
        add_new  = ctrl_new[CTRL_ADD_MSB:CTRL_ADD_LSB];
        // Writing consecutive-sequence mode restarts the sequence at ch0
        // before the pointer is used for this frame's channel choice.
        ptr_base = (wr_ctrl && seq_new == SEQ_CONSEC) ? 2'b00 : seq_ptr_q;
        if (seq_new == SEQ_CONSEC) begin
            conv_next = ptr_base;
            ptr_next  = (ptr_base == add_new) ? 2'b00 : ptr_base + 2'b01;
        end else begin
            conv_next = add_new;
            ptr_next  = ptr_base;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        d_out_d   = d_out_q;
        ctrl_d    = ctrl_q;
        seq_ptr_d = seq_ptr_q;
        conv_ch_d = conv_ch_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                d_out_d = 1'b0;
                // A clk_in edge coinciding with cs fall is dropped here.
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = tx_new;
                    d_out_d   = tx_new[FRAME_BITS-1];
                end
            end

            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    d_out_d = 1'b0;
                    if (bit_cnt_q == FULL_CNT) begin
                        done_d    = 1'b1;
                        ctrl_d    = ctrl_new;
                        conv_ch_d = conv_next;
                        seq_ptr_d = ptr_next;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_fall && bit_cnt_q != FULL_CNT) begin
                    rx_sr_d   = {rx_sr_q[FRAME_BITS-2:0], din_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Zeros shift in behind the word, so d_out drops to 0
                    // after the last data bit.
                    tx_sr_d   = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                    d_out_d   = tx_sr_q[FRAME_BITS-2];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign d_out      = d_out_q;
    assign ctrl_reg   = ctrl_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

    logic unused_sigs;
    assign unused_sigs = ^{cs_level, sclk_level, sclk_rise, din_rise, din_fall,
                           rx_sr_q[CTRL_BITS], tx_sr_q[FRAME_BITS-1]};

endmodule

// File: tb/tb_ad7324_spi_responder.sv
module tb_ad7324_spi_responder;

    localparam int H = 4; // system clocks per SPI half period

    logic        clk = 1'b0;
    logic        rst, cs, clk_in, d_in;
    logic        d_out;
    logic [51:0] ch_data;
    logic [11:0] ctrl_reg;
    logic        frame_done, frame_err;

    always #50 clk = ~clk;

    ad7324_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .clk_in     (clk_in),
        .d_in       (d_in),
        .d_out      (d_out),
        .ch_data    (ch_data),
        .ctrl_reg   (ctrl_reg),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    // Reference model: device registers as plain values.
    logic [11:0] m_ctrl;
    int          m_ptr;
    int          m_conv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0;
        m_ptr  = 0;
        m_conv = 0;
    endtask

    // Completed frame: optional control write, then pick next channel.
    // In sequence mode the channels cycle 0..ADD.
    task automatic model_frame(input logic [15:0] din);
        int add;
        if (din[15] && din[14:13] == 2'b00) begin
            m_ctrl = din[11:0];
            if (din[4:3] == 2'b11) m_ptr = 0;
        end
        add = int'(m_ctrl[11:10]);
        if (m_ctrl[4:3] == 2'b11) begin
            m_conv = m_ptr;
            m_ptr  = (m_ptr + 1) % (add + 1);
        end else begin
            m_conv = add;
        end
    endtask

    task automatic randomize_ch();
        for (int i = 0; i < 4; i++) ch_data[i*13 +: 13] = 13'($urandom);
    endtask

    task automatic spi_frame(input logic [15:0] din, input int nbits, input bit mid_change,
                             output logic [15:0] got);
        got = '0;
        cs  = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            d_in = din[15-i];
            repeat (H) @(negedge clk);
            got[15-i] = d_out;
            clk_in = 1'b0;
            if (mid_change && i == 7) randomize_ch();
            repeat (H) @(negedge clk);
            clk_in = 1'b1;
        end
        d_in = 1'b0;
        repeat (H) @(negedge clk);
        if (nbits == 16) check("dout_tail", 32'(d_out), 32'd0);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] din, input int nbits,
                             input bit mid_change, output logic [15:0] got);
        logic [15:0] exp_word, mask;
        int d0, e0;
        exp_word = {1'b0, 2'(m_conv), ch_data[m_conv*13 +: 13]};
        mask     = 16'hFFFF << (16 - nbits);
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(din, nbits, mid_change, got);
        check({tag, "_word"}, 32'(got & mask), 32'(exp_word & mask));
        if (nbits == 16) model_frame(din);
        check({tag, "_done"}, 32'(done_cnt - d0), (nbits == 16) ? 32'd1 : 32'd0);
        check({tag, "_err"},  32'(err_cnt - e0),  (nbits == 16) ? 32'd0 : 32'd1);
        check({tag, "_ctrl"}, 32'(ctrl_reg), 32'(m_ctrl));
        check({tag, "_idle"}, 32'(d_out), 32'd0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] din;
        int          nb;
        int          e0;
        logic [1:0]  exp_ids [4];

        rst = 1'b1; cs = 1'b1; clk_in = 1'b1; d_in = 1'b0;
        ch_data = '0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_dout",  32'(d_out),      32'd0);
        check("rst_ctrl",  32'(ctrl_reg),   32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_err",   32'(frame_err),  32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // 1: plain read of ch0
        randomize_ch();
        ch_data[12:0] = 13'h0123;
        run_frame("t1", 16'h0000, 16, 1'b0, got);
        check("t1_const", 32'(got), 32'h0123);

        // 2: select ch3, result appears one frame later
        randomize_ch();
        run_frame("t2w", 16'h8C00, 16, 1'b0, got);
        check("t2_ctrl_const", 32'(ctrl_reg), 32'hC00);
        run_frame("t2r", 16'h0000, 16, 1'b0, got);
        check("t2_const", 32'(got), 32'(16'h6000 | {3'b000, ch_data[51:39]}));

        // 3: consecutive sequence 0..2
        run_frame("t3w", 16'h8818, 16, 1'b0, got);
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2; exp_ids[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            randomize_ch();
            run_frame("t3r", 16'h0000, 16, 1'b0, got);
            check("t3_id", 32'(got[14:13]), 32'(exp_ids[i]));
        end

        // 4: aborted write after 9 clocks
        run_frame("t4a", 16'h8C00, 9, 1'b0, got);
        check("t4_ctrl_const", 32'(ctrl_reg), 32'h818);
        run_frame("t4r", 16'h0000, 16, 1'b0, got);

        // 5: ch_data changes mid-frame
        randomize_ch();
        run_frame("t5", 16'h0000, 16, 1'b1, got);

        // 6: reset at bit 7
        cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            d_in = 1'b1;
            repeat (H) @(negedge clk);
            clk_in = 1'b0;
            repeat (H) @(negedge clk);
            clk_in = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_dout", 32'(d_out),    32'd0);
        check("t6_ctrl", 32'(ctrl_reg), 32'd0);
        rst = 1'b0;
        d_in = 1'b0;
        model_reset();
        e0 = err_cnt;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_no_err", 32'(err_cnt - e0), 32'd0);
        randomize_ch();
        run_frame("t6r", 16'h0000, 16, 1'b0, got);
        check("t6_const", 32'(got), 32'({3'b000, ch_data[12:0]}));

        // Randomised traffic
        for (int n = 0; n < 24; n++) begin
            randomize_ch();
            din = 16'($urandom);
            if ($urandom_range(0, 1) == 1) din[15:13] = 3'b100;
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame("rnd", din, nb, ($urandom_range(0, 3) == 0), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
